// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory controller: RISC-V load/store
// funct3 encodings, per-size byte masks, the controller FSM state type and
// small helpers for request legality and word-crossing detection.
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LD_LO = 2'd1,
        LD_HI = 2'd2,
        ST_HI = 2'd3
    } state_e;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Byte mask of an access, selected by the size field funct3[1:0].
    function automatic logic [3:0] sizeMask(input logic [1:0] size);
        case (size)
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

    // Loads accept signed and unsigned widths; stores only b/h/w.
    function automatic logic opLegal(input logic [2:0] op, input logic we);
        case (op)
            OP_B, OP_H, OP_W: return 1'b1;
            OP_BU, OP_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    // An access crosses a word boundary when it needs bytes of the next word.
    function automatic logic isSplit(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return (off == 2'd3);
            2'b10:   return (off != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load data aligner: shifts the two-word window {hi, lo} down
// by the byte offset, then truncates to the access size and sign- or
// zero-extends according to the funct3 encoding.
//   op_i    funct3 of the load
//   off_i   byte offset of the access inside the low word
//   lo_i    word holding the first byte of the access
//   hi_i    following word (zero when the access does not cross a word)
//   data_o  right-justified, extended load result
// ---------------------------------------------------------------------------
module load_align
    import dmem_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [31:0] data_o
);

    logic [63:0] pair;
    logic [31:0] shifted;

    assign pair    = {hi_i, lo_i};
    assign shifted = 32'(pair >> {off_i, 3'b000});

    always_comb begin
        data_o = 32'd0;
        case (op_i)
            OP_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            OP_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            OP_W:    data_o = shifted;
            OP_BU:   data_o = {24'd0, shifted[7:0]};
            OP_HU:   data_o = {16'd0, shifted[15:0]};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// MEM-stage data memory controller. Accepts one load/store at a time,
// splits misaligned accesses that cross a word into two RAM beats, and
// returns a registered one-cycle completion with the extended load data.
//   clk, rst                  clock, synchronous active-low reset
//   req_valid/we/op/addr/wdata  request from the pipeline
//   req_ready, stall          accept handshake and its inverse for hazards
//   resp_valid/rdata/err      registered completion pulse
//   mem_addr/be/we/re/wdata   word-addressed RAM port
//   mem_rdata                 RAM read data, one cycle after mem_re
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic [29:0] hiAddr_q;
    logic [3:0]  hiBe_q;
    logic [31:0] hiWdata_q;
    logic [31:0] loData_q;
    logic        respValid_q;
    logic [31:0] respRdata_q;
    logic        respErr_q;

    logic [1:0]  reqOff;
    logic        reqLegal;
    logic        reqSplit;
    logic [7:0]  laneBe;
    logic [63:0] laneWdata;
    logic [29:0] hiAddr_d;
    logic [31:0] alignLo;
    logic [31:0] alignHi;
    logic [31:0] alignData;

    // Shifting the mask and data into an 8-lane / 64-bit window yields both
    // beats at once: the low half is the first beat, the high half the second.
    assign reqOff    = req_addr[1:0];
    assign reqLegal  = opLegal(req_op, req_we);
    assign reqSplit  = isSplit(req_op[1:0], reqOff);
    assign laneBe    = {4'b0000, sizeMask(req_op[1:0])} << reqOff;
    assign laneWdata = {32'd0, req_wdata} << {reqOff, 3'b000};
    assign hiAddr_d  = req_addr[31:2] + 30'd1;

    // In LD_LO the low word is still on mem_rdata; in LD_HI it was captured
    // and the high word is arriving.
    assign alignLo = (state_q == LD_LO) ? mem_rdata : loData_q;
    assign alignHi = (state_q == LD_HI) ? mem_rdata : 32'd0;

    load_align u_align (
        .op_i   (op_q),
        .off_i  (off_q),
        .lo_i   (alignLo),
        .hi_i   (alignHi),
        .data_o (alignData)
    );

    // Memory port: the first beat goes out combinationally in the accept
    // cycle, the second beat from the registered copy. Everything is held
    // at zero while reset is asserted.
    always_comb begin
        mem_addr  = 30'd0;
        mem_be    = 4'd0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 32'd0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (req_valid && reqLegal) begin
                        mem_addr  = req_addr[31:2];
                        mem_be    = laneBe[3:0];
                        mem_we    = req_we;
                        mem_re    = !req_we;
                        mem_wdata = laneWdata[31:0];
                    end
                end
                LD_LO: begin
                    if (split_q) begin
                        mem_addr = hiAddr_q;
                        mem_be   = hiBe_q;
                        mem_re   = 1'b1;
                    end
                end
                ST_HI: begin
                    mem_addr  = hiAddr_q;
                    mem_be    = hiBe_q;
                    mem_we    = 1'b1;
                    mem_wdata = hiWdata_q;
                end
                default: ;
            endcase
        end
    end

    // Controller FSM with registered response outputs. The response
    // registers default to idle every cycle so resp_valid is a single pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            off_q       <= 2'd0;
            split_q     <= 1'b0;
            hiAddr_q    <= 30'd0;
            hiBe_q      <= 4'd0;
            hiWdata_q   <= 32'd0;
            loData_q    <= 32'd0;
            respValid_q <= 1'b0;
            respRdata_q <= 32'd0;
            respErr_q   <= 1'b0;
        end else begin
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            respRdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        off_q     <= reqOff;
                        split_q   <= reqSplit;
                        hiAddr_q  <= hiAddr_d;
                        hiBe_q    <= laneBe[7:4];
                        hiWdata_q <= laneWdata[63:32];
                        if (!reqLegal) begin
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                        end else if (req_we) begin
                            if (reqSplit) begin
                                state_q <= ST_HI;
                            end else begin
                                respValid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= LD_LO;
                        end
                    end
                end
                LD_LO: begin
                    loData_q <= mem_rdata;
                    if (split_q) begin
                        state_q <= LD_HI;
                    end else begin
                        respValid_q <= 1'b1;
                        respRdata_q <= alignData;
                        state_q     <= IDLE;
                    end
                end
                LD_HI: begin
                    respValid_q <= 1'b1;
                    respRdata_q <= alignData;
                    state_q     <= IDLE;
                end
                ST_HI: begin
                    respValid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign stall      = ~req_ready;
    assign resp_valid = respValid_q;
    assign resp_rdata = respRdata_q;
    assign resp_err   = respErr_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-003 SHALL have port req_valid  in  1  MEM-stage access request.
REQ-004 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-005 SHALL have port req_op  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-006 SHALL have port req_addr  in  32  byte address.
REQ-007 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-008 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 SHALL have port stall  out  1  equals ~req_ready; drives hazard unit.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port resp_rdata  out  32  extended load data, registered; 0 for stores.
REQ-012 SHALL have port resp_err  out  1  illegal req_op, valid with resp_valid.
REQ-013 SHALL have port mem_addr  out  30  word address to RAM.
REQ-014 SHALL have port mem_be  out  4  byte enables; bit i = byte i.
REQ-015 SHALL have ports mem_we, mem_re  out  1 each  write / read strobe.
REQ-016 SHALL have port mem_wdata  out  32  lane-aligned write data.
REQ-017 SHALL have port mem_rdata  in  32  RAM read data, valid the cycle after mem_re.

Function
REQ-018 SHALL implement FSM states IDLE, LD_LO, LD_HI, ST_HI; req_ready=1 only in IDLE.
REQ-019 SHALL, in IDLE on acceptance (cycle T), drive the first-beat memory access combinationally in T: mem_addr=addr[31:2], off=addr[1:0].
REQ-020 SHALL define split: h/hu with off=3, w with off!=0; b/bu never split.
REQ-021 SHALL form lo-beat mem_be = (size mask << off)[3:0] and hi-beat mem_be = size mask >> (4-off); size mask 0001/0011/1111.
REQ-022 SHALL form mem_wdata lo = wdata << 8*off, hi = wdata >> 8*(4-off).
REQ-023 SHALL issue the hi beat at mem_addr+1 modulo 2^30 (0x3FFFFFFF wraps to 0).
REQ-024 SHALL time single-word load: T issue -> LD_LO in T+1 captures mem_rdata -> resp_valid at T+2, IDLE at T+2.
REQ-025 SHALL time split load: T lo issue -> T+1 LD_LO captures lo and issues hi -> T+2 LD_HI captures hi -> resp_valid at T+3.
REQ-026 SHALL time single store: T issue -> resp_valid at T+1, remain IDLE.
REQ-027 SHALL time split store: T lo issue -> T+1 ST_HI issues hi -> resp_valid at T+2.
REQ-028 SHALL compute load result as ({hi,lo} >> 8*off) truncated to size, sign-extended for b/h, zero-extended for bu/hu/w.
REQ-029 SHALL, for illegal req_op (011,110,111, or store with 1xx), issue no memory strobe, pulse resp_valid with resp_err=1, resp_rdata=0 at T+1.
REQ-030 SHALL ignore req_valid while req_ready=0; requester holds the request.
REQ-031 SHALL keep mem_we=mem_re=0 and mem_be=0 in any cycle with no beat issued.

Reset
REQ-032 SHALL, on rst=0 at a clock edge, enter IDLE and clear resp_valid, resp_rdata, resp_err and captured data.
REQ-033 SHALL abort an in-flight access on reset mid-operation with no resp_valid and no further beat; memory strobes are 0 throughout any cycle with rst=0.

Structure
REQ-034 SHALL take op encodings, size masks and FSM state encoding from shared package dmem_pkg.
REQ-035 SHALL place shift/extend of REQ-028 in one combinational sub-module load_align.

Verification
REQ-036 SHALL cover lw addr 0x100, RAM word 0x40=0xDEADBEEF -> mem_be=1111 at T, resp_rdata=0xDEADBEEF at T+2.
REQ-037 SHALL cover lh addr 0x103, words 0x40=0x80xxxxxx, 0x41=0xxxxxxx7F -> two reads, resp_rdata=0x00007F80 at T+3; lhu same; lh with byte 0xFF80 -> 0xFFFFFF80.
REQ-038 SHALL cover sw 0x12345678 addr 0x102 -> T: addr 0x40 be 1100 wdata 0x56780000; T+1: addr 0x41 be 0011 wdata 0x00001234; resp at T+2.
REQ-039 SHALL cover lw addr 0xFFFFFFFE -> hi beat mem_addr=0x00000000.
REQ-040 SHALL cover req_op=011 -> no strobes, resp_err=1 at T+1; rst=0 in LD_HI -> no resp_valid, IDLE next cycle.
